// File: rtl/game_timer_ctrl_if.sv
// Command and status bundle between the board inputs and the game timer.
// The controller drives commands (master); the timer reports count and state (slave).
interface game_timer_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             dir;
    logic [1:0]       speed;
    logic             lap;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] lap_count;
    logic             tick;
    logic             wrapped;
    logic             expired;
    logic             running;

    modport master (
        output start, stop, clear, load, load_value, dir, speed, lap,
        input  count, lap_count, tick, wrapped, expired, running
    );

    modport slave (
        input  start, stop, clear, load, load_value, dir, speed, lap,
        output count, lap_count, tick, wrapped, expired, running
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// Game step timer: prescaled run/pause counter with up/down, preset,
// speed select, lap capture and wrap-or-stop terminal handling.
module game_timer_ctrl #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 10,
    parameter int WIDTH   = 10,
    parameter int LIMIT   = 1023,
    parameter bit WRAP    = 1'b0
) (
    input  logic                CLOCK10M,
    input  logic                KEY0,
    game_timer_ctrl_if.slave    bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV + 1);
    localparam logic [PW-1:0]    DIV_V = PW'(DIV);
    localparam logic [WIDTH-1:0] LIM   = WIDTH'(LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [PW-1:0]    period;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lap_q, lap_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             at_term;
    logic             can_start;

    // A prescaler already past a shortened period steps on the next cycle.
    assign period    = DIV_V >> bus.speed;
    assign step      = (state_q == S_RUN) && ((presc_q + PW'(1)) >= period);
    assign at_term   = bus.dir ? (count_q == '0) : (count_q == LIM);
    assign can_start = (state_q == S_IDLE) || (state_q == S_PAUSE);

    always_ff @(posedge CLOCK10M or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            count_q <= '0;
            lap_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        lap_d   = lap_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (bus.lap) lap_d = count_q;

        // Accepted commands pre-empt any step falling in the same cycle.
        if (bus.clear) begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (bus.load && (state_q != S_RUN)) begin
            count_d = (bus.load_value > LIM) ? LIM : bus.load_value;
            if (state_q == S_DONE) state_d = S_PAUSE;
        end else if (bus.start && can_start) begin
            state_d = S_RUN;
        end else if (bus.stop && (state_q == S_RUN)) begin
            state_d = S_PAUSE;
        end else if (step) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (at_term && !WRAP) begin
                state_d = S_DONE;
            end else if (at_term) begin
                wrap_d  = 1'b1;
                count_d = bus.dir ? LIM : '0;
            end else if (bus.dir) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (state_q == S_RUN) begin
            presc_d = presc_q + PW'(1);
        end else if (state_q == S_IDLE) begin
            presc_d = '0;
        end
    end

    assign bus.count     = count_q;
    assign bus.lap_count = lap_q;
    assign bus.tick      = tick_q;
    assign bus.wrapped   = wrap_q;
    assign bus.expired   = (state_q == S_DONE);
    assign bus.running   = (state_q == S_RUN);
endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: stop-at-terminal and wrap instances driven in
// lockstep and compared every cycle against a cycle-count reference model.
module tb_game_timer_ctrl;
    localparam int W   = 4;
    localparam int LIM = 9;
    localparam int DIV = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         i_start, i_stop, i_clear, i_load, i_dir, i_lap;
    logic [W-1:0] i_lv;
    logic [1:0]   i_speed;

    game_timer_ctrl_if #(.WIDTH(W)) b0 ();
    game_timer_ctrl_if #(.WIDTH(W)) b1 ();

    assign b0.start = i_start;
    assign b0.stop = i_stop;
    assign b0.clear = i_clear;
    assign b0.load = i_load;
    assign b0.load_value = i_lv;
    assign b0.dir = i_dir;
    assign b0.speed = i_speed;
    assign b0.lap = i_lap;
    assign b1.start = i_start;
    assign b1.stop = i_stop;
    assign b1.clear = i_clear;
    assign b1.load = i_load;
    assign b1.load_value = i_lv;
    assign b1.dir = i_dir;
    assign b1.speed = i_speed;
    assign b1.lap = i_lap;

    game_timer_ctrl #(
        .CLK_HZ(100), .TICK_HZ(10), .WIDTH(W), .LIMIT(LIM), .WRAP(1'b0)
    ) u0 (
        .CLOCK10M(clk), .KEY0(rst_n), .bus(b0.slave)
    );

    game_timer_ctrl #(
        .CLK_HZ(100), .TICK_HZ(10), .WIDTH(W), .LIMIT(LIM), .WRAP(1'b1)
    ) u1 (
        .CLOCK10M(clk), .KEY0(rst_n), .bus(b1.slave)
    );

    int total = 0;
    int bad = 0;

    // Reference: index 0 stops at terminal, index 1 wraps.
    int m_mode[2];
    int m_el[2];
    int m_cnt[2];
    int m_lap[2];
    bit m_tick[2];
    bit m_wr[2];

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_mode[w] = M_IDLE;
            m_el[w] = 0;
            m_cnt[w] = 0;
            m_lap[w] = 0;
            m_tick[w] = 0;
            m_wr[w] = 0;
        end
    endtask

    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            int per;
            int c;
            bit term;
            per = DIV >> i_speed;
            c = m_cnt[w];
            if (i_lap) m_lap[w] = c;
            m_tick[w] = 0;
            m_wr[w] = 0;
            if (i_clear) begin
                m_mode[w] = M_IDLE;
                m_cnt[w] = 0;
                m_el[w] = 0;
            end else if (i_load && m_mode[w] != M_RUN) begin
                m_cnt[w] = (int'(i_lv) > LIM) ? LIM : int'(i_lv);
                if (m_mode[w] == M_DONE) m_mode[w] = M_PAUSE;
            end else if (i_start && (m_mode[w] == M_IDLE || m_mode[w] == M_PAUSE)) begin
                m_mode[w] = M_RUN;
            end else if (i_stop && m_mode[w] == M_RUN) begin
                m_mode[w] = M_PAUSE;
            end else if (m_mode[w] == M_RUN) begin
                if (m_el[w] + 1 >= per) begin
                    m_el[w] = 0;
                    m_tick[w] = 1;
                    term = i_dir ? (c == 0) : (c == LIM);
                    if (term && w == 0) begin
                        m_mode[w] = M_DONE;
                    end else begin
                        m_wr[w] = term;
                        m_cnt[w] = i_dir ? (c + LIM) % (LIM + 1) : (c + 1) % (LIM + 1);
                    end
                end else begin
                    m_el[w] = m_el[w] + 1;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        i_start = 0;
        i_stop = 0;
        i_clear = 0;
        i_load = 0;
        i_lap = 0;
    endtask

    function automatic logic [11:0] obs(int w);
        if (w == 0)
            return {b0.count, b0.lap_count, b0.tick, b0.wrapped, b0.expired, b0.running};
        return {b1.count, b1.lap_count, b1.tick, b1.wrapped, b1.expired, b1.running};
    endfunction

    function automatic logic [11:0] expv(int w);
        return {W'(m_cnt[w]), W'(m_lap[w]), m_tick[w], m_wr[w],
                m_mode[w] == M_DONE, m_mode[w] == M_RUN};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs(0) !== 12'h000 || obs(1) !== 12'h000) begin
            bad++;
            $display("FAIL reset_state got=%h/%h exp=000/000", obs(0), obs(1));
        end
        rst_n = 1;
        cyc();
        total++;
        if (obs(0) !== expv(0) || obs(1) !== expv(1)) begin
            bad++;
            $display("FAIL reset_idle got=%h/%h exp=%h/%h", obs(0), obs(1), expv(0), expv(1));
        end
    endtask

    task automatic test_count_up();
        int nt;
        i_speed = 0;
        i_dir = 0;
        i_start = 1;
        cyc();
        for (int n = 1; n <= 20; n++) begin
            cyc();
            total++;
            if (obs(0) !== expv(0) || obs(1) !== expv(1)) begin
                bad++;
                $display("FAIL up_cycle n=%0d got=%h/%h exp=%h/%h", n, obs(0), obs(1), expv(0), expv(1));
            end
        end
        total++;
        if (b0.count !== 4'd2 || b0.tick !== 1'b1) begin
            bad++;
            $display("FAIL up_two count=%0d tick=%b exp count=2 tick=1", b0.count, b0.tick);
        end
        i_speed = 2;
        nt = 0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            nt += int'(b0.tick);
            total++;
            if (obs(0) !== expv(0) || obs(1) !== expv(1)) begin
                bad++;
                $display("FAIL speed2_cycle got=%h/%h exp=%h/%h", obs(0), obs(1), expv(0), expv(1));
            end
        end
        total++;
        if (nt !== 4) begin
            bad++;
            $display("FAIL speed2_ticks got=%0d exp=4", nt);
        end
        i_speed = 0;
        for (int n = 0; n < 20 && m_el[0] != 6; n++) cyc();
        i_speed = 3;
        cyc();
        total++;
        if (b0.tick !== 1'b1 || obs(0) !== expv(0)) begin
            bad++;
            $display("FAIL speed_jump tick=%b got=%h exp tick=1 %h", b0.tick, obs(0), expv(0));
        end
        i_speed = 0;
        i_clear = 1;
        cyc();
    endtask

    task automatic test_terminal();
        i_speed = 3;
        i_dir = 0;
        i_start = 1;
        cyc();
        for (int n = 0; n < 9; n++) begin
            cyc();
            total++;
            if (obs(0) !== expv(0) || obs(1) !== expv(1)) begin
                bad++;
                $display("FAIL term_cycle got=%h/%h exp=%h/%h", obs(0), obs(1), expv(0), expv(1));
            end
        end
        total++;
        if (b0.count !== 4'd9 || b0.running !== 1'b1) begin
            bad++;
            $display("FAIL term_reach count=%0d run=%b exp count=9 run=1", b0.count, b0.running);
        end
        cyc();
        total++;
        if (b0.tick !== 1 || b0.count !== 4'd9 || b0.expired !== 1 || b0.running !== 0) begin
            bad++;
            $display("FAIL term_done tick=%b count=%0d exp=%b run=%b exp 1/9/1/0",
                     b0.tick, b0.count, b0.expired, b0.running);
        end
        total++;
        if (b1.count !== 4'd0 || b1.wrapped !== 1 || b1.tick !== 1) begin
            bad++;
            $display("FAIL term_wrap count=%0d wrapped=%b tick=%b exp 0/1/1", b1.count, b1.wrapped, b1.tick);
        end
        i_start = 1;
        cyc();
        total++;
        if (b0.expired !== 1 || b0.running !== 0 || obs(1) !== expv(1)) begin
            bad++;
            $display("FAIL done_start exp=%b run=%b exp 1/0", b0.expired, b0.running);
        end
        i_load = 1;
        i_lv = 3;
        cyc();
        total++;
        if (b0.count !== 4'd3 || b0.expired !== 0 || b0.running !== 0 || obs(1) !== expv(1)) begin
            bad++;
            $display("FAIL done_load count=%0d exp=%b run=%b exp 3/0/0", b0.count, b0.expired, b0.running);
        end
        i_clear = 1;
        cyc();
    endtask

    task automatic test_wrap_down();
        int seq[3];
        seq = '{1, 0, 9};
        i_load = 1;
        i_lv = 2;
        cyc();
        i_dir = 1;
        i_speed = 3;
        i_start = 1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++;
            if (b1.count !== W'(seq[k]) || b1.wrapped !== (k == 2) || obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL wrap_down k=%0d count=%0d wrapped=%b exp %0d/%0d",
                         k, b1.count, b1.wrapped, seq[k], k == 2);
            end
        end
        i_dir = 0;
        i_speed = 0;
        i_clear = 1;
        cyc();
    endtask

    task automatic test_pause_resume();
        int n;
        int nt;
        i_start = 1;
        cyc();
        for (int k = 0; k < 20 && m_el[0] != 6; k++) cyc();
        i_stop = 1;
        cyc();
        nt = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            nt += int'(b0.tick) + int'(b1.tick);
        end
        total++;
        if (nt !== 0 || obs(0) !== expv(0) || obs(1) !== expv(1) || b0.running !== 0) begin
            bad++;
            $display("FAIL pause_hold ticks=%0d got=%h/%h exp=%h/%h", nt, obs(0), obs(1), expv(0), expv(1));
        end
        i_start = 1;
        cyc();
        n = 0;
        do begin
            cyc();
            n++;
        end while (b0.tick !== 1'b1 && n < 20);
        total++;
        if (n !== 4) begin
            bad++;
            $display("FAIL resume_gap got=%0d exp=4", n);
        end
    endtask

    task automatic test_priority();
        i_clear = 1;
        i_start = 1;
        i_load = 1;
        i_lv = 7;
        cyc();
        total++;
        if (b0.count !== 0 || b0.running !== 0 || b1.count !== 0 || b1.running !== 0) begin
            bad++;
            $display("FAIL cmd_prio count=%0d/%0d run=%b/%b exp 0/0 0/0",
                     b0.count, b1.count, b0.running, b1.running);
        end
        i_load = 1;
        i_lv = 5;
        cyc();
        i_start = 1;
        cyc();
        for (int k = 0; k < 20 && m_el[0] != 9; k++) cyc();
        i_lap = 1;
        cyc();
        total++;
        if (b0.lap_count !== 4'd5 || b0.count !== 4'd6 || b0.tick !== 1) begin
            bad++;
            $display("FAIL lap_step lap=%0d count=%0d tick=%b exp 5/6/1", b0.lap_count, b0.count, b0.tick);
        end
        i_clear = 1;
        cyc();
        i_load = 1;
        i_lv = 14;
        cyc();
        total++;
        if (b0.count !== 4'd9 || b1.count !== 4'd9) begin
            bad++;
            $display("FAIL load_clamp got=%0d/%0d exp=9", b0.count, b1.count);
        end
    endtask

    task automatic test_async_reset();
        int n;
        i_start = 1;
        cyc();
        repeat (3) cyc();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        total++;
        if (obs(0) !== 12'h000 || obs(1) !== 12'h000) begin
            bad++;
            $display("FAIL async_reset got=%h/%h exp=000/000", obs(0), obs(1));
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        i_start = 1;
        cyc();
        n = 0;
        do begin
            cyc();
            n++;
        end while (b0.tick !== 1'b1 && n < 30);
        total++;
        if (n !== 10 || b0.count !== 4'd1) begin
            bad++;
            $display("FAIL reset_first_tick cycles=%0d count=%0d exp 10/1", n, b0.count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            i_clear = ($urandom % 64) == 0;
            i_load = ($urandom % 16) == 0;
            i_lv = W'($urandom % 16);
            i_start = ($urandom % 8) == 0;
            i_stop = ($urandom % 12) == 0;
            i_lap = ($urandom % 8) == 0;
            if ($urandom % 32 == 0) i_dir = ~i_dir;
            if ($urandom % 32 == 0) i_speed = 2'($urandom % 4);
            cyc();
            total++;
            if (obs(0) !== expv(0) || obs(1) !== expv(1)) begin
                bad++;
                $display("FAIL random n=%0d got=%h/%h exp=%h/%h", n, obs(0), obs(1), expv(0), expv(1));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_start = 0;
        i_stop = 0;
        i_clear = 0;
        i_load = 0;
        i_lv = 0;
        i_dir = 0;
        i_speed = 0;
        i_lap = 0;
        model_reset();
        test_reset();
        test_count_up();
        test_terminal();
        test_wrap_down();
        test_pause_resume();
        test_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
